fpnew_hub_sgnj_lane: RTL

FPNEW_HUB_SGNJ_LANE -- requirements
Module: fpnew_hub_sgnj_lane

---
 rtl/fpnew_hub_sgnj_lane.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fpnew_hub_sgnj_lane.sv
// Sign-injection lane (SGNJ/SGNJN/SGNJX) for HUB floating point behind an elastic
// valid/ready pipeline. Define HUB_LANE_SKID_EN to add a one-entry output skid register.
module fpnew_hub_sgnj_lane #(
  parameter int unsigned FpWidth     = 32,
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0][FpWidth-1:0] operands_i,
  input  logic [2:0]              rnd_mode_i,
  input  logic [TagWidth-1:0]     tag_i,
  input  logic                    mask_i,
  input  logic                    aux_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic [FpWidth-1:0]      result_o,
  output logic [4:0]              status_o,
  output logic                    extension_bit_o,
  output logic [TagWidth-1:0]     tag_o,
  output logic                    mask_o,
  output logic                    aux_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam int unsigned PayW = FpWidth + TagWidth + 2;

  function automatic logic [FpWidth-1:0] sgnj_f(input logic [FpWidth-1:0] a,
                                                input logic [FpWidth-1:0] b,
                                                input logic [2:0]         op);
    logic [FpWidth-1:0] r;
    r = a;
    case (op)
      3'b000:  r[FpWidth-1] = b[FpWidth-1];
      3'b001:  r[FpWidth-1] = ~b[FpWidth-1];
      3'b010:  r[FpWidth-1] = a[FpWidth-1] ^ b[FpWidth-1];
      default: r = a;
    endcase
    return r;
  endfunction

  logic [PayW-1:0] in_pay;
  logic [PayW-1:0] out_pay;

  assign in_pay = {sgnj_f(operands_i[0], operands_i[1], rnd_mode_i), tag_i, mask_i, aux_i};
  assign {result_o, tag_o, mask_o, aux_o} = out_pay;
  assign status_o        = 5'b00000;
  assign extension_bit_o = 1'b1;

  if (NumPipeRegs == 0) begin : g_comb
    // Pure wire-through; reset still forces the outputs to their idle values.
    logic unused_clk;
    assign unused_clk  = clk_i;
    assign in_ready_o  = out_ready_i & ~flush_i;
    assign out_valid_o = in_valid_i & ~flush_i & rst_ni;
    assign out_pay     = rst_ni ? in_pay : {PayW{1'b0}};
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned Last = NumPipeRegs - 1;

    logic [NumPipeRegs-1:0] vld_q, vld_d;
    logic [PayW-1:0]        pay_q [NumPipeRegs];
    logic [PayW-1:0]        pay_d [NumPipeRegs];
    logic [NumPipeRegs:0]   rdy;
    logic                   last_rdy;

    // Ready chain: a stage can take new data when empty or when it is draining this cycle.
    always_comb begin
      rdy              = '0;
      rdy[NumPipeRegs] = last_rdy;
      for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
        rdy[i] = ~vld_q[i] | rdy[i+1];
      end
    end

    assign in_ready_o = rdy[0] & ~flush_i;

    // Stage advance; payloads only move with a valid token and are untouched by flush.
    always_comb begin
      vld_d = vld_q;
      pay_d = pay_q;
      if (flush_i) begin
        vld_d = '0;
      end else begin
        if (rdy[0]) begin
          vld_d[0] = in_valid_i;
          if (in_valid_i) begin
            pay_d[0] = in_pay;
          end else begin
            pay_d[0] = pay_q[0];
          end
        end else begin
          vld_d[0] = vld_q[0];
        end
        for (int i = 1; i < int'(NumPipeRegs); i++) begin
          if (rdy[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
              pay_d[i] = pay_q[i-1];
            end else begin
              pay_d[i] = pay_q[i];
            end
          end else begin
            vld_d[i] = vld_q[i];
          end
        end
      end
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < int'(NumPipeRegs); i++) begin
          pay_q[i] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        pay_q <= pay_d;
      end
    end

`ifdef HUB_LANE_SKID_EN
    logic            skid_vld_q, skid_vld_d;
    logic [PayW-1:0] skid_pay_q, skid_pay_d;

    // Last stage sees only the registered skid-empty flag, cutting out_ready_i from in_ready_o.
    assign last_rdy = ~skid_vld_q;

    // Skid capture: park the last-stage op when the consumer stalls, release when it is taken.
    always_comb begin
      skid_vld_d = skid_vld_q;
      skid_pay_d = skid_pay_q;
      if (flush_i) begin
        skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
        if (out_ready_i) begin
          skid_vld_d = 1'b0;
        end else begin
          skid_vld_d = 1'b1;
        end
      end else if (vld_q[Last] && !out_ready_i) begin
        skid_vld_d = 1'b1;
        skid_pay_d = pay_q[Last];
      end else begin
        skid_vld_d = 1'b0;
      end
    end

    // Skid register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_vld_q <= 1'b0;
        skid_pay_q <= '0;
      end else begin
        skid_vld_q <= skid_vld_d;
        skid_pay_q <= skid_pay_d;
      end
    end

    assign out_valid_o = skid_vld_q | vld_q[Last];
    assign out_pay     = skid_vld_q ? skid_pay_q : pay_q[Last];
    assign busy_o      = (|vld_q) | skid_vld_q;
`else
    assign last_rdy    = out_ready_i;
    assign out_valid_o = vld_q[Last];
    assign out_pay     = pay_q[Last];
    assign busy_o      = |vld_q;
`endif
  end

endmodule
